// File: rtl/y86_pkg.sv
`default_nettype none
// ============================================================================
// Module      : y86_pkg
// Description : Y86-64 icode constants, status enum and fetch-queue entry type.
// Revision    : 1.0 - initial release
// ============================================================================
package y86_pkg;

    localparam logic [3:0] C_I_HALT   = 4'h0;
    localparam logic [3:0] C_I_NOP    = 4'h1;
    localparam logic [3:0] C_I_RRMOVQ = 4'h2;
    localparam logic [3:0] C_I_IRMOVQ = 4'h3;
    localparam logic [3:0] C_I_RMMOVQ = 4'h4;
    localparam logic [3:0] C_I_MRMOVQ = 4'h5;
    localparam logic [3:0] C_I_OPQ    = 4'h6;
    localparam logic [3:0] C_I_JXX    = 4'h7;
    localparam logic [3:0] C_I_CALL   = 4'h8;
    localparam logic [3:0] C_I_RET    = 4'h9;
    localparam logic [3:0] C_I_PUSHQ  = 4'hA;
    localparam logic [3:0] C_I_POPQ   = 4'hB;

    localparam logic [3:0] C_REG_NONE = 4'hF;

    // Entry address fields are stored at the widest supported PC width.
    localparam int C_ENTRY_PC_W = 64;

    typedef enum logic [1:0] {
        STAT_AOK = 2'd0,
        STAT_HLT = 2'd1,
        STAT_ADR = 2'd2,
        STAT_INS = 2'd3
    } stat_e;

    typedef struct packed {
        logic [3:0]              icode;
        logic [3:0]              ifun;
        logic [3:0]              ra;
        logic [3:0]              rb;
        logic [C_ENTRY_PC_W-1:0] valc;
        logic [C_ENTRY_PC_W-1:0] valp;
        stat_e                   stat;
    } fetch_entry_t;

    // Length is the opcode byte plus an optional regid byte and 8-byte constant.
    function automatic logic [3:0] instr_len(input logic need_regids, input logic need_valc);
        return 4'd1 + {3'd0, need_regids} + {need_valc, 3'd0};
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_split.sv
`default_nettype none
// ============================================================================
// Module      : instr_split
// Description : Combinational split of a 10-byte fetch window into Y86 fields.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_split
    import y86_pkg::*;
#(
    parameter int PC_W = 64
) (
    input  logic [PC_W-1:0] i_pc,
    input  logic [79:0]     i_data,
    input  logic            i_err,
    output logic [3:0]      o_icode,
    output logic [3:0]      o_ifun,
    output logic [3:0]      o_ra,
    output logic [3:0]      o_rb,
    output logic [PC_W-1:0] o_valc,
    output logic [PC_W-1:0] o_valp,
    output logic [1:0]      o_stat,
    output logic [PC_W-1:0] o_pred_pc
);

    logic [3:0]  w_icode;
    logic [7:0]  w_byte1;
    logic [63:0] w_word;
    logic        w_need_regids;
    logic        w_need_valc;
    logic        w_ins;
    stat_e       w_stat;

    assign w_icode = i_data[7:4];
    assign w_byte1 = i_data[15:8];

    always_comb begin
        w_need_regids = 1'b0;
        w_need_valc   = 1'b0;
        w_ins         = 1'b0;
        case (w_icode)
            C_I_HALT, C_I_NOP, C_I_RET: begin
                w_need_regids = 1'b0;
            end
            C_I_RRMOVQ, C_I_OPQ, C_I_PUSHQ, C_I_POPQ: begin
                w_need_regids = 1'b1;
            end
            C_I_IRMOVQ, C_I_RMMOVQ, C_I_MRMOVQ: begin
                w_need_regids = 1'b1;
                w_need_valc   = 1'b1;
            end
            C_I_JXX, C_I_CALL: begin
                w_need_valc = 1'b1;
            end
            default: begin
                w_ins = 1'b1;
            end
        endcase
    end

    // The constant follows the regid byte when one is present.
    assign w_word = w_need_regids ? i_data[79:16] : i_data[71:8];

    always_comb begin
        w_stat = STAT_AOK;
        if (i_err)
            w_stat = STAT_ADR;
        else if (w_ins)
            w_stat = STAT_INS;
        else if (w_icode == C_I_HALT)
            w_stat = STAT_HLT;
    end

    assign o_icode   = w_icode;
    assign o_ifun    = i_data[3:0];
    assign o_ra      = w_need_regids ? w_byte1[7:4] : C_REG_NONE;
    assign o_rb      = w_need_regids ? w_byte1[3:0] : C_REG_NONE;
    assign o_valc    = w_word[PC_W-1:0];
    assign o_valp    = i_pc + PC_W'(instr_len(w_need_regids, w_need_valc));
    assign o_stat    = w_stat;
    assign o_pred_pc = ((w_icode == C_I_JXX) || (w_icode == C_I_CALL)) ? o_valc : o_valp;

endmodule
`default_nettype wire

// File: rtl/pipe_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : pipe_fetch_queue
// Description : Y86 fetch stage with PC select and a circular instruction queue.
//               Define FETCH_Q_BYPASS_EN to forward pushes into an empty queue.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_fetch_queue
    import y86_pkg::*;
#(
    parameter int QDEPTH = 4,
    parameter int PC_W   = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [3:0]                    M_icode,
    input  logic                          M_Cnd,
    input  logic [PC_W-1:0]               M_valA,
    input  logic [3:0]                    W_icode,
    input  logic [PC_W-1:0]               W_valM,
    output logic [PC_W-1:0]               imem_addr,
    input  logic [79:0]                   imem_data,
    input  logic                          imem_err,
    input  logic                          D_ready,
    output logic                          D_valid,
    output logic [3:0]                    D_icode,
    output logic [3:0]                    D_ifun,
    output logic [3:0]                    D_rA,
    output logic [3:0]                    D_rB,
    output logic [PC_W-1:0]               D_valC,
    output logic [PC_W-1:0]               D_valP,
    output logic [1:0]                    D_stat,
    output logic [PC_W-1:0]               f_predPC,
    output logic [$clog2(QDEPTH+1)-1:0]   q_count
);

    localparam int C_PTR_W = $clog2(QDEPTH);
    localparam int C_CNT_W = $clog2(QDEPTH+1);

    logic [PC_W-1:0]    r_pred_pc;
    logic               r_halted;
    logic               r_ret_wait;
    logic [C_PTR_W-1:0] r_head;
    logic [C_PTR_W-1:0] r_tail;
    logic [C_CNT_W-1:0] r_count;
    fetch_entry_t       r_mem [QDEPTH];

    logic               w_redirect_m;
    logic               w_redirect_w;
    logic               w_redirect;
    logic [PC_W-1:0]    w_pc;
    logic [3:0]         w_s_icode;
    logic [3:0]         w_s_ifun;
    logic [3:0]         w_s_ra;
    logic [3:0]         w_s_rb;
    logic [PC_W-1:0]    w_s_valc;
    logic [PC_W-1:0]    w_s_valp;
    logic [1:0]         w_s_stat;
    logic [PC_W-1:0]    w_s_pred;
    fetch_entry_t       w_entry;
    fetch_entry_t       w_out;
    logic               w_pop_q;
    logic               w_full;
    logic               w_push;
    logic               w_bypass;
    logic               w_store;

    function automatic logic [C_PTR_W-1:0] ptr_inc(input logic [C_PTR_W-1:0] p);
        return (p == C_PTR_W'(QDEPTH-1)) ? '0 : p + C_PTR_W'(1);
    endfunction

    // A mispredicted jXX outranks a returning ret.
    assign w_redirect_m = (M_icode == C_I_JXX) && !M_Cnd;
    assign w_redirect_w = (W_icode == C_I_RET);
    assign w_redirect   = w_redirect_m || w_redirect_w;
    assign w_pc         = w_redirect_m ? M_valA : (w_redirect_w ? W_valM : r_pred_pc);
    assign imem_addr    = w_pc;

    instr_split #(
        .PC_W (PC_W)
    ) u_split (
        .i_pc      (w_pc),
        .i_data    (imem_data),
        .i_err     (imem_err),
        .o_icode   (w_s_icode),
        .o_ifun    (w_s_ifun),
        .o_ra      (w_s_ra),
        .o_rb      (w_s_rb),
        .o_valc    (w_s_valc),
        .o_valp    (w_s_valp),
        .o_stat    (w_s_stat),
        .o_pred_pc (w_s_pred)
    );

    always_comb begin
        w_entry                 = '0;
        w_entry.icode           = w_s_icode;
        w_entry.ifun            = w_s_ifun;
        w_entry.ra              = w_s_ra;
        w_entry.rb              = w_s_rb;
        w_entry.valc[PC_W-1:0]  = w_s_valc;
        w_entry.valp[PC_W-1:0]  = w_s_valp;
        w_entry.stat            = stat_e'(w_s_stat);
    end

    assign w_pop_q = (r_count != '0) && D_ready;
    assign w_full  = (r_count == C_CNT_W'(QDEPTH));
    assign w_push  = !rst && !w_redirect && !r_halted && !r_ret_wait && !(w_full && !w_pop_q);

`ifdef FETCH_Q_BYPASS_EN
    assign w_bypass = w_push && (r_count == '0);
`else
    assign w_bypass = 1'b0;
`endif

    // A forwarded entry that decode takes immediately never occupies a slot.
    assign w_store = w_push && !(w_bypass && D_ready);
    assign w_out   = w_bypass ? w_entry : r_mem[r_head];
    assign D_valid = (r_count != '0) || w_bypass;

    always_comb begin
        D_icode = C_I_NOP;
        D_ifun  = 4'h0;
        D_rA    = C_REG_NONE;
        D_rB    = C_REG_NONE;
        D_valC  = '0;
        D_valP  = '0;
        D_stat  = STAT_AOK;
        if (D_valid) begin
            D_icode = w_out.icode;
            D_ifun  = w_out.ifun;
            D_rA    = w_out.ra;
            D_rB    = w_out.rb;
            D_valC  = w_out.valc[PC_W-1:0];
            D_valP  = w_out.valp[PC_W-1:0];
            D_stat  = w_out.stat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pred_pc  <= '0;
            r_halted   <= 1'b0;
            r_ret_wait <= 1'b0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
        end else if (w_redirect) begin
            // Latch the redirect target so the next cycle fetches from it.
            r_pred_pc  <= w_pc;
            r_halted   <= 1'b0;
            r_ret_wait <= 1'b0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
        end else begin
            if (w_push) begin
                r_pred_pc <= w_s_pred;
                if (w_s_stat != STAT_AOK)
                    r_halted <= 1'b1;
                else if (w_s_icode == C_I_RET)
                    r_ret_wait <= 1'b1;
            end
            if (w_store)
                r_tail <= ptr_inc(r_tail);
            if (w_pop_q)
                r_head <= ptr_inc(r_head);
            r_count <= r_count + C_CNT_W'(w_store) - C_CNT_W'(w_pop_q);
        end
    end

    always_ff @(posedge clk) begin
        if (w_store)
            r_mem[r_tail] <= w_entry;
    end

    assign f_predPC = r_pred_pc;
    assign q_count  = r_count;

endmodule
`default_nettype wire

// File: tb/tb_pipe_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_fetch_queue
// Description : Directed scoreboard bench for pipe_fetch_queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_fetch_queue;

    localparam int QDEPTH  = 4;
    localparam int PC_W    = 64;
    localparam int C_CNT_W = $clog2(QDEPTH+1);

    logic               clk = 1'b0;
    logic               rst;
    logic [3:0]         M_icode;
    logic               M_Cnd;
    logic [PC_W-1:0]    M_valA;
    logic [3:0]         W_icode;
    logic [PC_W-1:0]    W_valM;
    logic [PC_W-1:0]    imem_addr;
    logic [79:0]        imem_data;
    logic               imem_err;
    logic               D_ready;
    logic               D_valid;
    logic [3:0]         D_icode;
    logic [3:0]         D_ifun;
    logic [3:0]         D_rA;
    logic [3:0]         D_rB;
    logic [PC_W-1:0]    D_valC;
    logic [PC_W-1:0]    D_valP;
    logic [1:0]         D_stat;
    logic [PC_W-1:0]    f_predPC;
    logic [C_CNT_W-1:0] q_count;

    logic [7:0]  mem [0:1023];
    logic [63:0] mem_lim;

    typedef struct {
        string       name;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        bit          chk_valc;
        logic [63:0] valp;
        logic [1:0]  stat;
        bit          stat_only;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    pipe_fetch_queue #(
        .QDEPTH (QDEPTH),
        .PC_W   (PC_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .M_icode   (M_icode),
        .M_Cnd     (M_Cnd),
        .M_valA    (M_valA),
        .W_icode   (W_icode),
        .W_valM    (W_valM),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .imem_err  (imem_err),
        .D_ready   (D_ready),
        .D_valid   (D_valid),
        .D_icode   (D_icode),
        .D_ifun    (D_ifun),
        .D_rA      (D_rA),
        .D_rB      (D_rB),
        .D_valC    (D_valC),
        .D_valP    (D_valP),
        .D_stat    (D_stat),
        .f_predPC  (f_predPC),
        .q_count   (q_count)
    );

    always_comb begin
        imem_data = '0;
        for (int i = 0; i < 10; i++)
            imem_data[8*i +: 8] = mem[10'(imem_addr + 64'(i))];
        imem_err = (imem_addr >= mem_lim);
    end

    // Monitor: every accepted head entry is matched against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        bit   ok;
        if (!rst && D_valid && D_ready &&
            !((M_icode == 4'h7) && !M_Cnd) && (W_icode != 4'h9)) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_output got icode=%h valP=%h stat=%0d want none",
                         D_icode, D_valP, D_stat);
            end else begin
                e  = sb.pop_front();
                ok = (D_stat == e.stat);
                if (!e.stat_only) begin
                    ok = ok && (D_icode == e.icode) && (D_ifun == e.ifun) &&
                         (D_rA == e.ra) && (D_rB == e.rb) && (D_valP == e.valp);
                    if (e.chk_valc)
                        ok = ok && (D_valC == e.valc);
                end
                if (!ok) begin
                    failures++;
                    $display("FAIL entry_%0s got icode=%h ifun=%h rA=%h rB=%h valC=%h valP=%h stat=%0d want icode=%h ifun=%h rA=%h rB=%h valC=%h valP=%h stat=%0d",
                             e.name, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP, D_stat,
                             e.icode, e.ifun, e.ra, e.rb, e.valc, e.valp, e.stat);
                end
            end
        end
    end

    task automatic expect_entry(input string n, input logic [3:0] ic, input logic [3:0] fn,
                                input logic [3:0] ra, input logic [3:0] rb,
                                input logic [63:0] vc, input bit cvc,
                                input logic [63:0] vp, input logic [1:0] st, input bit so);
        exp_t e;
        e.name = n; e.icode = ic; e.ifun = fn; e.ra = ra; e.rb = rb;
        e.valc = vc; e.chk_valc = cvc; e.valp = vp; e.stat = st; e.stat_only = so;
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %0s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic reset_hold();
        rst     = 1'b1;
        D_ready = 1'b0;
        M_icode = 4'h0;
        M_Cnd   = 1'b1;
        M_valA  = '0;
        W_icode = 4'h0;
        W_valM  = '0;
        mem_lim = 64'd1024;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        sb.delete();
        step(2);
    endtask

    task automatic drain(input string name, input int max_cycles);
        for (int c = 0; c < max_cycles && (sb.size() != 0 || q_count != 0); c++)
            step(1);
        chk(name, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        // Reset state.
        reset_hold();
        @(negedge clk);
        chk("rst_q_count", 64'(q_count), 64'd0);
        chk("rst_d_valid", 64'(D_valid), 64'd0);
        chk("rst_d_icode", 64'(D_icode), 64'h1);
        chk("rst_d_ra",    64'(D_rA),    64'hF);
        chk("rst_d_rb",    64'(D_rB),    64'hF);
        chk("rst_d_stat",  64'(D_stat),  64'd0);
        chk("rst_pred",    f_predPC,     64'd0);
        chk("rst_addr",    imem_addr,    64'd0);

        // irmovq $0x10,%rax ; nop ; halt
        reset_hold();
        mem[0] = 8'h30; mem[1] = 8'hF0; mem[2] = 8'h10; mem[10] = 8'h10;
        expect_entry("irmovq", 4'h3, 4'h0, 4'hF, 4'h0, 64'h10, 1'b1, 64'd10, 2'd0, 1'b0);
        expect_entry("nop",    4'h1, 4'h0, 4'hF, 4'hF, 64'h0,  1'b0, 64'd11, 2'd0, 1'b0);
        expect_entry("halt",   4'h0, 4'h0, 4'hF, 4'hF, 64'h0,  1'b0, 64'd12, 2'd1, 1'b0);
        D_ready = 1'b1;
        rst     = 1'b0;
        @(negedge clk);
        chk("t2_first_addr", imem_addr, 64'd0);
`ifdef FETCH_Q_BYPASS_EN
        chk("t2_bypass_valid", 64'(D_valid), 64'd1);
        chk("t2_bypass_count", 64'(q_count), 64'd0);
`else
        chk("t2_valid_c0", 64'(D_valid), 64'd0);
        @(negedge clk);
        chk("t2_valid_c1", 64'(D_valid), 64'd1);
`endif
        step(1);
        drain("t2_drain", 20);
        step(2);
        chk("t2_pred",  f_predPC,     64'd12);
        chk("t2_count", 64'(q_count), 64'd0);

        // Back-pressure: six nops then out of range.
        reset_hold();
        for (int i = 0; i < 6; i++) begin
            mem[i] = 8'h10;
            expect_entry("bp_nop", 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 1'b0, 64'(i + 1), 2'd0, 1'b0);
        end
        expect_entry("bp_adr", 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 1'b0, 64'd0, 2'd2, 1'b1);
        mem_lim = 64'd6;
        rst = 1'b0;
        step(8);
        @(negedge clk);
        chk("t3_count_sat", 64'(q_count), 64'd4);
        chk("t3_pred_freeze", f_predPC, 64'd4);
        chk("t3_head_valp", D_valP, 64'd1);
        @(posedge clk);
        #2;
        D_ready = 1'b1;
        step(1);
        chk("t3_full_pushpop_count", 64'(q_count), 64'd4);
        chk("t3_full_pushpop_pred", f_predPC, 64'd5);
        drain("t3_drain", 30);
        chk("t3_pred_end", f_predPC, 64'd7);

        // jXX prediction then mispredict redirect.
        reset_hold();
        mem[0] = 8'h70; mem[1] = 8'h20;
        mem[32'h20] = 8'h74; mem[32'h22] = 8'h01;
        mem[32'h100] = 8'h10; mem[32'h101] = 8'h10;
        mem[32'h29] = 8'h60; mem[32'h2A] = 8'h12;
        rst = 1'b0;
        step(2);
        @(negedge clk);
        chk("t4_jxx_target", imem_addr, 64'h100);
        step(3);
        @(negedge clk);
        chk("t4_count", 64'(q_count), 64'd4);
        chk("t4_head_icode", 64'(D_icode), 64'h7);
        chk("t4_head_valc", D_valC, 64'h20);
        chk("t4_head_valp", D_valP, 64'd9);
        @(posedge clk);
        #2;
        M_icode = 4'h7; M_Cnd = 1'b0; M_valA = 64'h29;
        expect_entry("opq",   4'h6, 4'h0, 4'h1, 4'h2, 64'h0, 1'b0, 64'h2B, 2'd0, 1'b0);
        expect_entry("halt2", 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 1'b0, 64'h2C, 2'd1, 1'b0);
        @(negedge clk);
        chk("t4_redirect_addr", imem_addr, 64'h29);
        step(1);
        M_icode = 4'h0; M_Cnd = 1'b1;
        D_ready = 1'b1;
        chk("t4_flush_count", 64'(q_count), 64'd0);
        chk("t4_next_pc", imem_addr, 64'h29);
        drain("t4_drain", 20);

        // ret stalls fetch until W returns.
        reset_hold();
        mem[0] = 8'h70; mem[1] = 8'h40;
        mem[32'h40] = 8'h90;
        mem[32'h80] = 8'h30; mem[32'h81] = 8'hF3;
        mem[32'h82] = 8'hEF; mem[32'h83] = 8'hCD; mem[32'h84] = 8'hAB; mem[32'h85] = 8'h89;
        mem[32'h86] = 8'h67; mem[32'h87] = 8'h45; mem[32'h88] = 8'h23; mem[32'h89] = 8'h01;
        expect_entry("jmp", 4'h7, 4'h0, 4'hF, 4'hF, 64'h40, 1'b1, 64'd9,  2'd0, 1'b0);
        expect_entry("ret", 4'h9, 4'h0, 4'hF, 4'hF, 64'h0,  1'b0, 64'h41, 2'd0, 1'b0);
        D_ready = 1'b1;
        rst = 1'b0;
        step(8);
        chk("t5_stall_count", 64'(q_count), 64'd0);
        chk("t5_stall_pred", f_predPC, 64'h41);
        chk("t5_stall_sb", 64'(sb.size()), 64'd0);
        @(negedge clk);
        chk("t5_stall_valid", 64'(D_valid), 64'd0);
        @(posedge clk);
        #2;
        W_icode = 4'h9; W_valM = 64'h80;
        expect_entry("irmovq_big", 4'h3, 4'h0, 4'hF, 4'h3, 64'h0123456789ABCDEF, 1'b1, 64'h8A, 2'd0, 1'b0);
        expect_entry("halt3",      4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 1'b0, 64'h8B, 2'd1, 1'b0);
        @(negedge clk);
        chk("t5_ret_addr", imem_addr, 64'h80);
        step(1);
        W_icode = 4'h0;
        chk("t5_flush_count", 64'(q_count), 64'd0);
        drain("t5_drain", 20);

        // Illegal opcode, then address error, then mid-run reset.
        reset_hold();
        mem[0] = 8'hF0;
        mem_lim = 64'h200;
        expect_entry("ins", 4'hF, 4'h0, 4'hF, 4'hF, 64'h0, 1'b0, 64'd1, 2'd3, 1'b0);
        D_ready = 1'b1;
        rst = 1'b0;
        step(6);
        chk("t6_ins_count", 64'(q_count), 64'd0);
        chk("t6_ins_pred", f_predPC, 64'd1);
        chk("t6_ins_sb", 64'(sb.size()), 64'd0);
        M_icode = 4'h7; M_Cnd = 1'b0; M_valA = 64'h300;
        expect_entry("adr", 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 1'b0, 64'h0, 2'd2, 1'b1);
        step(1);
        M_icode = 4'h0; M_Cnd = 1'b1;
        drain("t6_adr_drain", 20);
        D_ready = 1'b0;
        for (int i = 0; i < 4; i++) mem[i] = 8'h10;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(5);
        chk("t6_fill_count", 64'(q_count), 64'd4);
        rst = 1'b1;
        step(1);
        @(negedge clk);
        chk("t6_rst_count", 64'(q_count), 64'd0);
        chk("t6_rst_valid", 64'(D_valid), 64'd0);
        chk("t6_rst_icode", 64'(D_icode), 64'h1);
        chk("t6_rst_addr", imem_addr, 64'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        chk("t6_post_rst_addr", imem_addr, 64'd0);
        step(2);
        chk("t6_final_sb", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
